consmax_row_packer: RTL

Downstream companion of the ConSmax stage. It packs the stream of ODATA_BIT-wide integer exp-scores (one per cycle, no backpressure) into PACK_NUM-lane words aligned to softmax rows. It buffers those words in a small FIFO and hands them to the next matmul/SRAM-write stage over a valid/ready handshake. A row that ends mid-word emits a partial word with a lane mask and a last flag. FIFO overflow is detected and reported, because ConSmax cannot be stalled.

---
 rtl/consmax_row_packer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/consmax_row_packer.sv
// -----------------------------------------------------------------------------
// consmax_row_packer
//   Packs the ConSmax exp-score stream (one ODATA_BIT element per cycle, no
//   backpressure) into PACK_NUM-lane words aligned to softmax rows. Each word
//   carries a lane mask and a row-last flag. Words are buffered in a small FIFO
//   and handed downstream over a valid/ready handshake. ConSmax cannot stall,
//   so a word that finds the FIFO full is dropped and ovf_err is raised.
//
// Ports
//   clk, rstn         clock, asynchronous active-low reset
//   cfg_row_len       elements per row (0 behaves as 1), latched at row start
//   err_clr           synchronous clear of ovf_err
//   idata/idata_valid element stream from ConSmax
//   odata/odata_mask/odata_last/odata_valid/odata_ready   FIFO head handshake
//   fifo_cnt          FIFO occupancy
//   ovf_err           sticky flag: at least one word was dropped
// -----------------------------------------------------------------------------
module consmax_row_packer #(
   parameter int ODATA_BIT  = 8,
   parameter int PACK_NUM   = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int ROW_BIT    = 8
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [ROW_BIT-1:0]              cfg_row_len,
   input  logic                            err_clr,
   input  logic [ODATA_BIT-1:0]            idata,
   input  logic                            idata_valid,
   output logic [PACK_NUM*ODATA_BIT-1:0]   odata,
   output logic [PACK_NUM-1:0]             odata_mask,
   output logic                            odata_last,
   output logic                            odata_valid,
   input  logic                            odata_ready,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_cnt,
   output logic                            ovf_err
);

   localparam int LW = $clog2(PACK_NUM);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int DW = PACK_NUM * ODATA_BIT;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   logic [LW-1:0]       lane_cnt_q, lane_cnt_d;
   logic [ROW_BIT-1:0]  elem_cnt_q, elem_cnt_d;
   logic [ROW_BIT-1:0]  row_len_q, row_len_d;
   logic [DW-1:0]       stage_q, stage_d;
   logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                ovf_q, ovf_d;

   logic [DW-1:0]       mem_data_q [FIFO_DEPTH];
   logic [PACK_NUM-1:0] mem_mask_q [FIFO_DEPTH];
   logic                mem_last_q [FIFO_DEPTH];

   logic [ROW_BIT-1:0]  row_len_s;
   logic                row_end_s;
   logic                word_done_s;
   logic [DW-1:0]       word_data_s;
   logic [PACK_NUM-1:0] word_mask_s;
   logic                pop_s;
   logic                push_ok_s;

   // Effective row length and assembly of the word that would be pushed now.
   always_comb begin
      row_len_s   = row_len_q;
      word_data_s = stage_q;
      word_mask_s = '0;
      // At row start the live config is used; mid-row the latched value rules.
      if (elem_cnt_q == '0) begin
         if (cfg_row_len == '0) begin
            row_len_s = ROW_BIT'(1);
         end else begin
            row_len_s = cfg_row_len;
         end
      end else begin
         row_len_s = row_len_q;
      end
      row_end_s   = (elem_cnt_q == (row_len_s - ROW_BIT'(1)));
      word_done_s = idata_valid && (row_end_s || (lane_cnt_q == LW'(PACK_NUM - 1)));
      for (int i = 0; i < PACK_NUM; i++) begin
         if (lane_cnt_q == LW'(i)) begin
            word_data_s[i*ODATA_BIT +: ODATA_BIT] = idata;
         end else begin
            word_data_s[i*ODATA_BIT +: ODATA_BIT] = stage_q[i*ODATA_BIT +: ODATA_BIT];
         end
         if (LW'(i) <= lane_cnt_q) begin
            word_mask_s[i] = 1'b1;
         end else begin
            word_mask_s[i] = 1'b0;
         end
      end
   end

   // Next-state logic for counters, staging, FIFO pointers and the error flag.
   always_comb begin
      lane_cnt_d = lane_cnt_q;
      elem_cnt_d = elem_cnt_q;
      row_len_d  = row_len_q;
      stage_d    = stage_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;

      if (idata_valid) begin
         row_len_d = row_len_s;
         if (row_end_s) begin
            elem_cnt_d = '0;
         end else begin
            elem_cnt_d = elem_cnt_q + ROW_BIT'(1);
         end
         // Counters advance even if the word is dropped, keeping row alignment.
         if (word_done_s) begin
            lane_cnt_d = '0;
            stage_d    = '0;
         end else begin
            lane_cnt_d = lane_cnt_q + LW'(1);
            stage_d    = word_data_s;
         end
      end else begin
         lane_cnt_d = lane_cnt_q;
      end

      pop_s     = (cnt_q != '0) && odata_ready;
      // A full FIFO still takes a word when the head leaves in the same cycle.
      push_ok_s = word_done_s && ((cnt_q < DEPTH_C) || pop_s);

      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_ok_s, pop_s})
         2'b10:   cnt_d = cnt_q + CW'(1);
         2'b01:   cnt_d = cnt_q - CW'(1);
         default: cnt_d = cnt_q;
      endcase

      // Set dominates clear.
      if (word_done_s && !push_ok_s) begin
         ovf_d = 1'b1;
      end else if (err_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
   end

   // Control and status registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane_cnt_q <= '0;
         elem_cnt_q <= '0;
         row_len_q  <= '0;
         stage_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
      end else begin
         lane_cnt_q <= lane_cnt_d;
         elem_cnt_q <= elem_cnt_d;
         row_len_q  <= row_len_d;
         stage_q    <= stage_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
      end
   end

   // FIFO storage; data, mask and last travel together as one entry.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_data_q[i] <= '0;
            mem_mask_q[i] <= '0;
            mem_last_q[i] <= 1'b0;
         end
      end else if (push_ok_s) begin
         mem_data_q[wr_ptr_q] <= word_data_s;
         mem_mask_q[wr_ptr_q] <= word_mask_s;
         mem_last_q[wr_ptr_q] <= row_end_s;
      end else begin
         mem_data_q[wr_ptr_q] <= mem_data_q[wr_ptr_q];
      end
   end

   // Head is read straight from storage and forced to zero when empty.
   assign odata_valid = (cnt_q != '0);
   assign odata       = odata_valid ? mem_data_q[rd_ptr_q] : '0;
   assign odata_mask  = odata_valid ? mem_mask_q[rd_ptr_q] : '0;
   assign odata_last  = odata_valid ? mem_last_q[rd_ptr_q] : 1'b0;
   assign fifo_cnt    = cnt_q;
   assign ovf_err     = ovf_q;

endmodule
